// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and the memory slave.
// One valid/ready transaction per access; address and write fields are held while valid is high.
interface load_store_unit_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_address;
    logic [3:0]  mem_wstrobe;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_address,
        output mem_wstrobe,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_address,
        input  mem_wstrobe,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one bus transaction per load/store, aligned extraction and
// sign/zero extension for loads, byte strobes and lane replication for stores.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] load_data,
    load_store_unit_if.master bus
);
    typedef logic [31:0] word_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       is_load_reg;
    logic [2:0] funct3_reg;
    logic [1:0] offset_reg;
    logic       misaligned_reg;
    word_t      load_data_reg;
    word_t      mem_address_reg;
    word_t      mem_wdata_reg;
    logic [3:0] mem_wstrobe_reg;

    // Request decode: low funct3 bits give the size; 011/110/111 fall into word.
    logic req_byte;
    logic req_half;
    logic req_word;
    logic req_misaligned;

    assign req_byte       = (funct3[1:0] == 2'b00);
    assign req_half       = (funct3[1:0] == 2'b01);
    assign req_word       = !(req_byte || req_half);
    assign req_misaligned = (req_half && address[0]) ||
                            (req_word && (address[1:0] != 2'b00));

    logic [3:0] strobe_next;
    word_t      wdata_next;

    always_comb begin
        strobe_next = 4'b0000;
        if (is_store) begin
            if (req_byte)
                strobe_next = 4'b0001 << address[1:0];
            else if (req_half)
                strobe_next = 4'b0011 << address[1:0];
            else
                strobe_next = 4'b1111;
        end
    end

    // Each byte lane carries the low byte, the matching halfword byte, or its own word byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            assign wdata_next[8*gi +: 8] = req_byte ? store_data[7:0] :
                                           req_half ? store_data[8*(gi%2) +: 8] :
                                                      store_data[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    word_t       load_next;

    assign rd_byte = bus.mem_rdata[{offset_reg, 3'b000} +: 8];
    assign rd_half = bus.mem_rdata[{offset_reg[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_next = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_next = {24'd0, rd_byte};
            3'b001:  load_next = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_next = {16'd0, rd_half};
            default: load_next = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = req_misaligned ? ST_DONE : ST_BUS;
            ST_BUS:  if (bus.mem_ready) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            is_load_reg     <= 1'b0;
            funct3_reg      <= 3'b000;
            offset_reg      <= 2'b00;
            misaligned_reg  <= 1'b0;
            load_data_reg   <= '0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
            mem_wstrobe_reg <= 4'b0000;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        is_load_reg     <= is_load;
                        funct3_reg      <= funct3;
                        offset_reg      <= address[1:0];
                        misaligned_reg  <= req_misaligned;
                        load_data_reg   <= '0;
                        mem_address_reg <= {address[31:2], 2'b00};
                        mem_wdata_reg   <= wdata_next;
                        mem_wstrobe_reg <= strobe_next;
                    end
                end
                ST_BUS: begin
                    // Stores leave load_data at the zero written on acceptance.
                    if (bus.mem_ready && is_load_reg)
                        load_data_reg <= load_next;
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state_reg != ST_IDLE);
    assign done            = (state_reg == ST_DONE);
    assign misaligned      = misaligned_reg;
    assign load_data       = load_data_reg;
    assign bus.mem_valid   = (state_reg == ST_BUS);
    assign bus.mem_address = mem_address_reg;
    assign bus.mem_wstrobe = mem_wstrobe_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: arithmetic access model plus literal vectors.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] load_data;

    load_store_unit_if bus_if ();

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .address    (address),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .load_data  (load_data),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    int cmp_count  = 0;
    int fail_count = 0;
    int done_count = 0;
    bit chk_en     = 0;

    bit          exp_pending = 0;
    bit          exp_load;
    bit          exp_mis;
    logic [31:0] exp_ld;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd;
    logic [31:0] exp_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Access semantics from size/offset arithmetic: size in bytes, shift right, mask, extend.
    function automatic void model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] rd,
                                  output bit mis, output logic [31:0] ldv,
                                  output logic [3:0] strb, output logic [31:0] wd);
        int size;
        int off;
        longint unsigned m;
        longint unsigned s;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(a[1:0]);
        mis  = (off % size) != 0;
        strb = ld ? 4'b0000 : 4'(((1 << size) - 1) << off);
        m    = (64'd1 << (8 * size)) - 1;
        wd   = '0;
        for (int i = 0; i < 4; i += size)
            wd |= 32'((longint'(sd) & m) << (8 * i));
        ldv = '0;
        if (ld && !mis) begin
            s = (longint'(rd) >> (8 * off)) & m;
            if (size < 4 && !f3[2] && s[8*size-1])
                s |= ~m;
            ldv = s[31:0];
        end
    endfunction

    // Cycle-by-cycle check of bus fields and completion results against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (done) begin
                chk("done_expected", 32'(exp_pending), 32'd1);
                chk("misaligned", 32'(misaligned), 32'(exp_mis));
                chk("load_data", load_data, exp_ld);
                done_count++;
                exp_pending = 0;
            end
            if (bus_if.mem_valid) begin
                chk("valid_expected", 32'(exp_pending), 32'd1);
                chk("mem_address", bus_if.mem_address, exp_addr);
                chk("mem_wstrobe", 32'(bus_if.mem_wstrobe), 32'(exp_strb));
                if (!exp_load)
                    chk("mem_wdata", bus_if.mem_wdata, exp_wd);
            end
        end
    end

    task automatic issue(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd);
        model(ld, f3, a, sd, rd, exp_mis, exp_ld, exp_strb, exp_wd);
        exp_addr    = {a[31:2], 2'b00};
        exp_load    = ld;
        exp_pending = 1;
        start       = 1'b1;
        is_load     = ld;
        is_store    = !ld;
        funct3      = f3;
        address     = a;
        store_data  = sd;
    endtask

    task automatic run(input string tag, input bit ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       input int waits, input bit poke, input bit lit_mis,
                       input logic [31:0] lit_ld, input logic [3:0] lit_strb,
                       input logic [31:0] lit_wd, input logic [31:0] lit_addr);
        int d0;
        @(negedge clk);
        d0 = done_count;
        issue(ld, f3, a, sd, rd);
        @(negedge clk);
        start = 1'b0;
        chk("busy_c1", 32'(busy), 32'd1);
        if (lit_mis) begin
            chk("mis_done_c1", 32'(done), 32'd1);
            chk("mis_flag_lit", 32'(misaligned), 32'd1);
            chk("mis_load_data_lit", load_data, lit_ld);
            chk("mis_no_valid", 32'(bus_if.mem_valid), 32'd0);
        end else begin
            chk("addr_lit", bus_if.mem_address, lit_addr);
            chk("strobe_lit", 32'(bus_if.mem_wstrobe), 32'(lit_strb));
            if (!ld)
                chk("wdata_lit", bus_if.mem_wdata, lit_wd);
            for (int w = 0; w <= waits; w++) begin
                if (w > 0) @(negedge clk);
                chk("valid_hold", 32'(bus_if.mem_valid), 32'd1);
                chk("done_early", 32'(done), 32'd0);
                bus_if.mem_ready = (w == waits);
                bus_if.mem_rdata = (w == waits) ? rd : ~rd;
                if (poke) begin
                    start    = (w == 0);
                    is_load  = 1'b0;
                    is_store = 1'b1;
                    funct3   = 3'b010;
                    address  = a ^ 32'h0000_0100;
                end
            end
            @(negedge clk);
            bus_if.mem_ready = 1'b0;
            start = 1'b0;
            chk("done_pulse", 32'(done), 32'd1);
            chk("load_data_lit", load_data, lit_ld);
            chk("aligned_flag", 32'(misaligned), 32'd0);
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("valid_after", 32'(bus_if.mem_valid), 32'd0);
        chk("done_count", 32'(done_count - d0), 32'd1);
        $display("txn %s ld=%0d f3=%b addr=%h waits=%0d -> load_data=%h mis=%0d",
                 tag, ld, f3, a, waits, exp_ld, exp_mis);
    endtask

    initial begin
        int d0;
        reset            = 1'b1;
        start            = 1'b1;
        is_load          = 1'b1;
        is_store         = 1'b0;
        funct3           = 3'b010;
        address          = 32'h1234_567C;
        store_data       = 32'hA5A5_A5A5;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'hFFFF_FFFF;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_address", bus_if.mem_address, 32'd0);
        chk("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
        chk("rst_mem_wstrobe", 32'(bus_if.mem_wstrobe), 32'd0);
        reset            = 1'b0;
        start            = 1'b0;
        bus_if.mem_ready = 1'b0;
        chk_en           = 1;
        @(negedge clk);
        chk("rst_start_ignored", 32'(busy), 32'd0);
        $display("txn reset: outputs idle after reset");

        //  tag        ld f3      addr          sdata         rdata        w  pk mis  lit_ld        strb     wdata         addr
        run("lb",      1, 3'b000, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 0, 0, 0, 32'hFFFF_FF80, 4'b0000, 32'h0,        32'h0000_1000);
        run("lbu",     1, 3'b100, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 0, 0, 0, 32'h0000_0080, 4'b0000, 32'h0,        32'h0000_1000);
        run("lb2",     1, 3'b000, 32'h0000_1002, 32'h0,        32'h80AA_BBCC, 1, 0, 0, 32'hFFFF_FFAA, 4'b0000, 32'h0,        32'h0000_1000);
        run("lbu1",    1, 3'b100, 32'h0000_1001, 32'h0,        32'h80AA_BBCC, 0, 0, 0, 32'h0000_00BB, 4'b0000, 32'h0,        32'h0000_1000);
        run("sh",      0, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0,        3, 0, 0, 32'h0,        4'b1100, 32'h5678_5678, 32'h0000_2000);
        run("lw_mis",  1, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
        run("lhu",     1, 3'b101, 32'h0000_0002, 32'h0,        32'hF00D_0000, 1, 0, 0, 32'h0000_F00D, 4'b0000, 32'h0,        32'h0000_0000);
        run("lh_poke", 1, 3'b001, 32'h0000_0002, 32'h0,        32'hF00D_0000, 2, 1, 0, 32'hFFFF_F00D, 4'b0000, 32'h0,        32'h0000_0000);
        run("lh_pos",  1, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_7FFF, 0, 0, 0, 32'h0000_7FFF, 4'b0000, 32'h0,        32'h0000_0000);
        run("lw",      1, 3'b010, 32'h0000_0010, 32'h0,        32'hCAFE_BABE, 2, 0, 0, 32'hCAFE_BABE, 4'b0000, 32'h0,        32'h0000_0010);
        run("lw_011",  1, 3'b011, 32'h0000_0020, 32'h0,        32'h1234_5678, 0, 0, 0, 32'h1234_5678, 4'b0000, 32'h0,        32'h0000_0020);
        run("sw",      0, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,        1, 0, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0000_0008);
        run("lh_mis",  1, 3'b001, 32'h0000_0003, 32'h0,        32'h0,        0, 0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
        run("sh_mis",  0, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0,        0, 0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
        run("l110_mis",1, 3'b110, 32'h0000_0005, 32'h0,        32'h0,        0, 0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);

        // Abandon a stalled sw with a reset in its second bus cycle.
        @(negedge clk);
        d0 = done_count;
        issue(0, 3'b010, 32'h0000_3000, 32'h1122_3344, 32'h0);
        @(negedge clk);
        start = 1'b0;
        chk("rst_mid_valid_c1", 32'(bus_if.mem_valid), 32'd1);
        @(negedge clk);
        chk("rst_mid_valid_c2", 32'(bus_if.mem_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        exp_pending = 0;
        chk("rst_mid_valid_c3", 32'(bus_if.mem_valid), 32'd0);
        chk("rst_mid_busy_c3", 32'(busy), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_no_done", 32'(done), 32'd0);
        end
        chk("rst_mid_done_count", 32'(done_count - d0), 32'd0);
        $display("txn sw_reset: abandoned at cycle 2, no completion");

        run("sb",      0, 3'b000, 32'h0000_4001, 32'h0000_00AB, 32'h0,        1, 0, 0, 32'h0,        4'b0010, 32'hABAB_ABAB, 32'h0000_4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule
